// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int RST_PULSE_DEF   = 16;
    localparam int STABLE_CYC_DEF  = 1024;
    localparam int LOSS_FILT_DEF   = 4;
    localparam int TIMEOUT_CYC_DEF = 360000;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4
    } pll_state_t;

    // Largest of four values, used to size the shared phase timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low clear to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock, and gates the downstream system reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE   = RST_PULSE_DEF,
    parameter int STABLE_CYC  = STABLE_CYC_DEF,
    parameter int LOSS_FILT   = LOSS_FILT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             force_relock,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             pll_ok,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int TMR_MAX = max4(RST_PULSE, STABLE_CYC, LOSS_FILT, TIMEOUT_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST    = TMR_W'(LOSS_FILT - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);

    pll_state_t       state;
    pll_state_t       next_state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             loss_inc;
    logic             retry_inc;
    logic             locked_s;
    logic             pll_rst_nxt;
    logic             run_nxt;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    // One timer serves every phase; it is cleared on each state change.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ok    <= 1'b0;
        end else begin
            state     <= next_state;
            timer     <= timer_nxt;
            pll_rst   <= pll_rst_nxt;
            sys_rst_n <= run_nxt;
            pll_ok    <= run_nxt;
        end
    end

    always_comb begin
        next_state = state;
        timer_nxt  = timer + TMR_W'(1);
        loss_inc   = 1'b0;
        retry_inc  = 1'b0;
        case (state)
            PLL_RST: begin
                if (timer == RST_LAST) begin
                    next_state = WAIT_LOCK;
                    timer_nxt  = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = STABLE;
                    timer_nxt  = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    next_state = PLL_RST;
                    timer_nxt  = '0;
                    retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    timer_nxt  = '0;
                end else if (timer == STABLE_LAST) begin
                    next_state = RUN;
                    timer_nxt  = '0;
                end
            end
            RUN: begin
                if (locked_s) begin
                    timer_nxt = '0;
                end else if (timer == LOSS_LAST) begin
                    next_state = LOST;
                    timer_nxt  = '0;
                end
            end
            LOST: begin
                next_state = WAIT_LOCK;
                timer_nxt  = '0;
                loss_inc   = 1'b1;
            end
            default: begin
                next_state = PLL_RST;
                timer_nxt  = '0;
            end
        endcase
        // A forced relock overrides everything except an already-running PLL reset.
        if (force_relock && (state != PLL_RST)) begin
            next_state = PLL_RST;
            timer_nxt  = '0;
            loss_inc   = 1'b0;
            retry_inc  = 1'b0;
        end
    end

    always_comb begin
        pll_rst_nxt = (next_state == PLL_RST);
        run_nxt     = (next_state == RUN);
    end

    assign state_o = state;

    // Status counters saturate; a clear request beats a same-cycle increment.
    always_ff @(posedge refclk) begin
        if (!rst_n || clr_cnt) begin
            loss_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            if (loss_inc && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
            if (retry_inc && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       locked;
    logic       force_relock;
    logic       clr_cnt;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ok;
    logic [2:0] state_o;
    logic [3:0] loss_cnt;
    logic [3:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pll_lock_supervisor #(
        .RST_PULSE   (4),
        .STABLE_CYC  (8),
        .LOSS_FILT   (3),
        .TIMEOUT_CYC (50),
        .CNT_W       (4)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .force_relock (force_relock),
        .clr_cnt      (clr_cnt),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .pll_ok       (pll_ok),
        .state_o      (state_o),
        .loss_cnt     (loss_cnt),
        .retry_cnt    (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance n rising edges; inputs change and outputs are sampled 1ns after each edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input int st, input int prst, input int srst, input int ok);
        checkOutput({tag, "_state"}, state_o, st);
        checkOutput({tag, "_pll_rst"}, pll_rst, prst);
        checkOutput({tag, "_sys_rst_n"}, sys_rst_n, srst);
        checkOutput({tag, "_pll_ok"}, pll_ok, ok);
    endtask

    initial begin
        rst_n        = 1'b0;
        locked       = 1'b0;
        force_relock = 1'b0;
        clr_cnt      = 1'b0;
        applyStimulus(3);
        checkStatus("reset", 0, 1, 0, 0);
        checkOutput("reset_loss", loss_cnt, 0);
        checkOutput("reset_retry", retry_cnt, 0);

        // Power-up: 4-cycle PLL reset pulse, then lock qualification.
        rst_n = 1'b1;
        applyStimulus(3);
        checkStatus("rst_pulse_hold", 0, 1, 0, 0);
        applyStimulus(1);
        checkStatus("rst_pulse_end", 1, 0, 0, 0);
        applyStimulus(5);
        locked = 1'b1;
        applyStimulus(3);
        checkStatus("enter_stable", 2, 0, 0, 0);
        applyStimulus(7);
        checkStatus("stable_last", 2, 0, 0, 0);
        applyStimulus(1);
        checkStatus("first_run", 3, 0, 1, 1);
        checkOutput("first_run_loss", loss_cnt, 0);

        // Two-cycle glitch is filtered.
        locked = 1'b0;
        applyStimulus(2);
        locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("short_glitch_state", state_o, 3);
            checkOutput("short_glitch_sys_rst_n", sys_rst_n, 1);
        end

        // Three-cycle drop is a real loss.
        locked = 1'b0;
        applyStimulus(3);
        locked = 1'b1;
        applyStimulus(1);
        checkStatus("loss_filter_run", 3, 0, 1, 1);
        applyStimulus(1);
        checkStatus("lost", 4, 0, 0, 0);
        checkOutput("lost_loss_cnt", loss_cnt, 0);
        applyStimulus(1);
        checkStatus("lost_to_wait", 1, 0, 0, 0);
        checkOutput("lost_loss_inc", loss_cnt, 1);
        applyStimulus(9);
        checkStatus("relock_run", 3, 0, 1, 1);

        // Forced relock from RUN.
        force_relock = 1'b1;
        applyStimulus(1);
        force_relock = 1'b0;
        checkStatus("force_relock", 0, 1, 0, 0);
        checkOutput("force_loss_kept", loss_cnt, 1);
        checkOutput("force_retry_kept", retry_cnt, 0);
        applyStimulus(4);
        checkStatus("force_wait", 1, 0, 0, 0);
        applyStimulus(9);
        checkStatus("force_run", 3, 0, 1, 1);

        // Clear coincident with a LOST increment.
        locked = 1'b0;
        applyStimulus(3);
        locked = 1'b1;
        applyStimulus(2);
        checkStatus("lost2", 4, 0, 0, 0);
        checkOutput("lost2_loss_cnt", loss_cnt, 1);
        clr_cnt = 1'b1;
        applyStimulus(1);
        clr_cnt = 1'b0;
        checkOutput("clr_wins_loss", loss_cnt, 0);
        checkOutput("clr_wait_state", state_o, 1);
        applyStimulus(9);
        checkStatus("clr_run", 3, 0, 1, 1);

        // Lock drop at stable count 5 restarts qualification.
        force_relock = 1'b1;
        applyStimulus(1);
        force_relock = 1'b0;
        applyStimulus(5);
        checkStatus("stable_entry", 2, 0, 0, 0);
        applyStimulus(3);
        locked = 1'b0;
        applyStimulus(1);
        locked = 1'b1;
        applyStimulus(1);
        checkStatus("stable_cnt5", 2, 0, 0, 0);
        applyStimulus(1);
        checkStatus("stable_glitch", 1, 0, 0, 0);
        applyStimulus(8);
        checkStatus("stable_clean7", 2, 0, 0, 0);
        applyStimulus(1);
        checkStatus("stable_clean_run", 3, 0, 1, 1);

        // Permanent loss: LOST, then repeated timeouts with retry saturation.
        locked = 1'b0;
        applyStimulus(5);
        checkStatus("lost3", 4, 0, 0, 0);
        applyStimulus(1);
        checkOutput("lost3_loss_cnt", loss_cnt, 1);
        checkOutput("lost3_wait", state_o, 1);
        applyStimulus(49);
        checkOutput("timeout_edge_state", state_o, 1);
        checkOutput("timeout_edge_retry", retry_cnt, 0);
        applyStimulus(1);
        checkStatus("timeout1", 0, 1, 0, 0);
        checkOutput("timeout1_retry", retry_cnt, 1);
        applyStimulus(4);
        checkOutput("timeout1_wait", state_o, 1);
        for (int n = 2; n <= 16; n++) begin
            applyStimulus(50);
            checkOutput("timeout_state", state_o, 0);
            checkOutput("timeout_pll_rst", pll_rst, 1);
            checkOutput("retry_sat", retry_cnt, (n > 15) ? 15 : n);
            applyStimulus(4);
            checkOutput("timeout_wait", state_o, 1);
        end

        // Lock arriving on the timeout cycle wins.
        applyStimulus(47);
        locked = 1'b1;
        applyStimulus(2);
        checkOutput("lock_vs_timeout_pre", state_o, 1);
        applyStimulus(1);
        checkOutput("lock_vs_timeout", state_o, 2);
        checkOutput("lock_vs_timeout_retry", retry_cnt, 15);
        applyStimulus(8);
        checkStatus("final_run", 3, 0, 1, 1);
        checkOutput("final_run_loss", loss_cnt, 1);
        checkOutput("final_run_retry", retry_cnt, 15);

        // One-cycle reset while in RUN.
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        checkStatus("mid_reset", 0, 1, 0, 0);
        checkOutput("mid_reset_loss", loss_cnt, 0);
        checkOutput("mid_reset_retry", retry_cnt, 0);
        applyStimulus(3);
        checkStatus("rerun_pulse", 0, 1, 0, 0);
        applyStimulus(1);
        checkStatus("rerun_wait", 1, 0, 0, 0);
        applyStimulus(8);
        checkStatus("rerun_stable", 2, 0, 0, 0);
        applyStimulus(1);
        checkStatus("rerun_run", 3, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
